// File: rtl/mux4.sv
// Four-input single-bit mux with a registered output, select-change detection,
// a saturating select-change counter and registered edge pulses on the output.
module mux4 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d0,
  input  logic             d1,
  input  logic             d2,
  input  logic             d3,
  input  logic [1:0]       sel,
  output logic             z,
  output logic             z_q,
  output logic             sel_chg,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             z_rise,
  output logic             z_fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             zr_q,      zr_d;
  logic [1:0]       sel_q,     sel_d;
  logic             primed_q,  primed_d;
  logic             chg_q,     chg_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             rise_q,    rise_d;
  logic             fall_q,    fall_d;

  // Unknown select bits fall through to default so simulation shows X on z.
  always_comb begin
    case (sel)
      2'b00:   z = d0;
      2'b01:   z = d1;
      2'b10:   z = d2;
      2'b11:   z = d3;
      default: z = 1'bx;
    endcase
  end

  // primed_q masks change/edge detection on the first edge after reset,
  // when sel_q and zr_q hold reset values rather than real history.
  always_comb begin
    zr_d     = z;
    sel_d    = sel;
    primed_d = 1'b1;
    chg_d    = primed_q && (sel != sel_q);
    rise_d   = primed_q && !zr_q && z;
    fall_d   = primed_q && zr_q && !z;
    cnt_d    = cnt_q;
    if (chg_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zr_q     <= 1'b0;
      sel_q    <= 2'b00;
      primed_q <= 1'b0;
      chg_q    <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      zr_q     <= zr_d;
      sel_q    <= sel_d;
      primed_q <= primed_d;
      chg_q    <= chg_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign z_q     = zr_q;
  assign sel_chg = chg_q;
  assign chg_cnt = cnt_q;
  assign z_rise  = rise_q;
  assign z_fall  = fall_q;

endmodule

// File: tb/tb_mux4.sv
// Bench for mux4: directed scenarios then random traffic, checked against an
// edge-by-edge behavioural model; a CNT_W=2 instance shares the stimulus.
module tb_mux4;

  logic       clk;
  logic       rst;
  logic       d0, d1, d2, d3;
  logic [1:0] sel;

  logic       z, z_q, sel_chg, z_rise, z_fall;
  logic [7:0] chg_cnt;
  logic       z2, z_q2, sel_chg2, z_rise2, z_fall2;
  logic [1:0] chg_cnt2;

  int n_checks = 0;
  int n_err    = 0;

  // model state
  logic       m_zq, m_primed, m_chg, m_rise, m_fall;
  logic [1:0] m_sel;
  int         m_cnt, m_cnt2;

  mux4 u_dut (
    .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .sel(sel),
    .z(z), .z_q(z_q), .sel_chg(sel_chg), .chg_cnt(chg_cnt),
    .z_rise(z_rise), .z_fall(z_fall)
  );

  mux4 #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .sel(sel),
    .z(z2), .z_q(z_q2), .sel_chg(sel_chg2), .chg_cnt(chg_cnt2),
    .z_rise(z_rise2), .z_fall(z_fall2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_z(input logic [3:0] dv, input logic [1:0] s);
    return dv[s];
  endfunction

  task automatic drive(input logic [3:0] dv, input logic [1:0] s);
    {d3, d2, d1, d0} = dv;
    sel = s;
  endtask

  task automatic check_comb(input string tag);
    #1;
    check({tag, ".z"},  {31'd0, z},  {31'd0, ref_z({d3, d2, d1, d0}, sel)});
    check({tag, ".z2"}, {31'd0, z2}, {31'd0, ref_z({d3, d2, d1, d0}, sel)});
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".z_q"},     {31'd0, z_q},     {31'd0, m_zq});
    check({tag, ".sel_chg"}, {31'd0, sel_chg}, {31'd0, m_chg});
    check({tag, ".chg_cnt"}, {24'd0, chg_cnt}, m_cnt);
    check({tag, ".z_rise"},  {31'd0, z_rise},  {31'd0, m_rise});
    check({tag, ".z_fall"},  {31'd0, z_fall},  {31'd0, m_fall});
    check({tag, ".cnt2"},    {30'd0, chg_cnt2}, m_cnt2);
    check({tag, ".chg2"},    {31'd0, sel_chg2}, {31'd0, m_chg});
  endtask

  // One clock: the model advances from the inputs present at the edge,
  // registered outputs are compared on the following falling edge.
  task automatic step(input logic r, input string tag);
    logic zn;
    rst = r;
    @(posedge clk);
    zn = ref_z({d3, d2, d1, d0}, sel);
    if (r) begin
      m_zq = 0; m_sel = 0; m_primed = 0; m_chg = 0;
      m_rise = 0; m_fall = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      m_chg  = m_primed && (sel != m_sel);
      m_rise = m_primed && !m_zq && zn;
      m_fall = m_primed && m_zq && !zn;
      if (m_chg) begin
        m_cnt  = (m_cnt  + 1 > 255) ? 255 : m_cnt + 1;
        m_cnt2 = (m_cnt2 + 1 > 3)   ? 3   : m_cnt2 + 1;
      end
      m_zq = zn; m_sel = sel; m_primed = 1;
    end
    @(negedge clk);
    check_regs(tag);
    check_comb(tag);
  endtask

  initial begin
    logic [3:0] dv;
    logic [1:0] s;
    int exp_cnt2 [5] = '{1, 2, 3, 3, 3};

    drive(4'b0000, 2'b00);
    rst = 1'b1;
    m_zq = 0; m_sel = 0; m_primed = 0; m_chg = 0;
    m_rise = 0; m_fall = 0; m_cnt = 0; m_cnt2 = 0;
    step(1'b1, "reset0");
    step(1'b1, "reset1");

    // zero-latency combinational path, also while in reset
    check_comb("comb_d0_0");
    d0 = 1'b1;
    #1 check("comb_d0_1", {31'd0, z}, 32'd1);
    d0 = 1'b0;
    #1 check("comb_d0_0b", {31'd0, z}, 32'd0);

    // select walk with d = 1,0,1,0
    drive(4'b0101, 2'b00);
    for (int i = 0; i < 4; i++) begin
      sel = i[1:0];
      #1 check("sel_walk", {31'd0, z}, {31'd0, ~i[0]});
    end

    // first edge after reset never flags a change
    step(1'b1, "rst_a");
    drive(4'b0000, 2'b10);
    step(1'b0, "hold10");
    check("first_edge_no_chg", {31'd0, sel_chg}, 32'd0);
    sel = 2'b11;
    step(1'b0, "chg11");
    check("one_chg", {31'd0, sel_chg}, 32'd1);
    check("cnt_one", {24'd0, chg_cnt}, 32'd1);
    step(1'b0, "hold11");
    check("pulse_ends", {31'd0, sel_chg}, 32'd0);

    // saturation of the narrow counter over consecutive changes
    step(1'b1, "rst_b");
    drive(4'b0000, 2'b00);
    step(1'b0, "prime");
    for (int i = 0; i < 5; i++) begin
      sel = sel + 2'd1;
      step(1'b0, "sat_step");
      check("sat_cnt2", {30'd0, chg_cnt2}, exp_cnt2[i]);
    end

    // d0 toggle on sel=00: z_q lags one cycle, single rise then single fall
    drive(4'b0000, 2'b00);
    step(1'b0, "tog_base");
    d0 = 1'b1;
    step(1'b0, "tog_up");
    check("rise_pulse", {31'd0, z_rise}, 32'd1);
    check("zq_up", {31'd0, z_q}, 32'd1);
    d0 = 1'b0;
    step(1'b0, "tog_down");
    check("fall_pulse", {31'd0, z_fall}, 32'd1);
    check("no_rise", {31'd0, z_rise}, 32'd0);
    step(1'b0, "tog_idle");

    // non-selected inputs do not disturb the path
    drive(4'b0010, 2'b01);
    step(1'b0, "nsel_a");
    d3 = 1'b1; d0 = 1'b1; d2 = 1'b1;
    step(1'b0, "nsel_b");
    check("nsel_zq", {31'd0, z_q}, 32'd1);

    // reset mid-operation with chg_cnt=3 and z_q=1
    step(1'b1, "rst_c");
    drive(4'b0001, 2'b00);
    step(1'b0, "mid_prime");
    for (int i = 1; i <= 3; i++) begin
      sel = i[1:0];
      d1 = 1'b1; d2 = 1'b1; d3 = 1'b1;
      step(1'b0, "mid_chg");
    end
    check("mid_cnt3", {24'd0, chg_cnt}, 32'd3);
    check("mid_zq1", {31'd0, z_q}, 32'd1);
    step(1'b1, "mid_rst");
    check("mid_rst_zq", {31'd0, z_q}, 32'd0);
    check("mid_rst_cnt", {24'd0, chg_cnt}, 32'd0);
    check("mid_rst_z_tracks", {31'd0, z}, 32'd1);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      dv = 4'($urandom_range(0, 15));
      s  = 2'($urandom_range(0, 3));
      drive(dv, s);
      step(($urandom_range(0, 39) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
